led_bank_shifter: RTL
=====================

# led_bank_shifter

Serialises LED frame data into one bank of daisy-chained LED shift-register drivers: one shift clock, two latch enables and nine parallel data lines, with each data line feeding one string. It sits directly downstream of the FMC-facing register file. The register file writes per-lane words into a double-half buffer and issues a start pulse. This block then clocks the words out MSB-first and pulses the selected latch. Four instances drive banks B0–B3.

## Interface
- WORD_BITS, 16, bits shifted per lane per frame
- CLK_DIV, 4, system clocks per half-period of shift clock C (≥1)
- LE_CYCLES, 2, system clocks the latch enable is held high (≥1)
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write strobe for buffer (one word per cycle)
- wr_half  in  1  buffer half: 0 → LE0 strings, 1 → LE1 strings
- wr_lane  in  4  lane index 0–8; values 9–15 ignored
- wr_data  in  WORD_BITS  word for {half, lane}
- start  in  1  single-cycle request to shift out a half
- start_half  in  1  half to shift/latch, sampled with start
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- overrun  out  1  one-cycle pulse when start arrives while busy
- C  out  1  shift clock to bank
- LE0, LE1  out  1  latch enables, half 0 / half 1
- D  out  9  serial data, D[i] drives lane i

## Operation
- Buffer: 2×9×WORD_BITS registers. The buffer is written when wr_en=1 and wr_lane≤8. Writes are accepted in any state. Out-of-range lanes are dropped silently.
- Snapshot: an accepted start copies the selected half's 9 words into shift registers. Later writes, and a write in the same cycle as start, affect only later frames.
- FSM states:
  - IDLE: waits for start. On start → LOAD snapshot → SHIFT.
  - SHIFT: WORD_BITS bits, each taking one low phase of C (CLK_DIV cycles) followed by one high phase (CLK_DIV cycles). D is updated only at the start of a low phase, MSB first. After the last high phase → LATCH.
  - LATCH: C=0, D=0, and LE{start_half}=1 for LE_CYCLES cycles → DONE.
  - DONE: done=1, busy=0 for one cycle → IDLE.
- start while busy=1: the request is ignored, overrun pulses the next cycle, and the current frame is unaffected.
- start in the DONE cycle: accepted (busy=0 in that cycle).
- Only the selected LE ever rises. LE0 and LE1 are never high simultaneously.
- Reset, asynchronous, from any state:
  - outputs go to C=0, LE0=LE1=0, D=0, busy=0, done=0, overrun=0
  - FSM goes to IDLE and counters clear
  - buffer contents are cleared to 0
  - a frame interrupted mid-shift is never latched.
- All outputs are registered (no combinational paths from inputs).

## Timing
- start sampled high at edge t (IDLE).
- t+1: busy=1, C=0, D=bit WORD_BITS−1 of each lane.
- Bit k (counting from MSB as k=0):
  - C rises at t+1+(2k+1)·CLK_DIV
  - C falls at t+1+(2k+2)·CLK_DIV, and the next bit appears on D at that same edge.
- LE high from t+1+2·WORD_BITS·CLK_DIV for LE_CYCLES cycles.
- done=1, busy=0 at t+1+2·WORD_BITS·CLK_DIV+LE_CYCLES.
- Defaults: done at t+131, with 16 rising edges of C per frame.
- D is stable ≥CLK_DIV cycles before and after each rising edge of C.
- Counters: bit counter ⌈log2(WORD_BITS+1)⌉ bits; divider counts 0..CLK_DIV−1 and wraps.

## Test plan
- Reset:
  - stimulus: hold resetn=0 for 5 cycles, then release.
  - response: all outputs are 0 and stay 0 for 20 cycles with no start.
- Single frame with defaults:
  - stimulus: write half 0, lane 0 = 16'hA5C3 and lane 8 = 16'h8001. Pulse start with start_half=0 at t.
  - response: 16 rising edges of C. Sampling D[0] on those edges gives A5C3. D[8] gives 8001. All other lanes give 0. LE0 is high at t+129..t+130, LE1 stays 0, and done pulses at t+131.
- Snapshot:
  - stimulus: write half 1, lane 3 = 16'hFFFF. Start on half 1. Three cycles later, write lane 3 = 16'h0000.
  - response: the frame shifts FFFF and LE1 pulses. A second start shifts 0000.
- Overrun and back-to-back:
  - stimulus: pulse start at t, again at t+50, and again at t+131.
  - response: the start at t+50 gives overrun=1 at t+51 with the frame unchanged. The start at t+131 is accepted and busy=1 at t+132.
- Reset mid-shift:
  - stimulus: assert resetn=0 at t+60.
  - response: C, D and busy go to 0 immediately. LE0 and LE1 never pulse. Buffer reads back as 0 on the next frame.
- Lane range:
  - stimulus: write with wr_lane=9, data 16'h1234.
  - response: all D lines shift 0 on the next frame.

Source files
------------

// File: rtl/led_bank_shifter.sv
// led_bank_shifter: serialises one half of a 2x9-lane word buffer into a bank
// of daisy-chained LED shift-register drivers (shift clock C, nine data lines
// D, two latch enables). A start pulse snapshots the selected half, clocks the
// words out MSB-first, then pulses the matching latch enable.
module led_bank_shifter #(
    parameter int WORD_BITS = 16,
    parameter int CLK_DIV   = 4,
    parameter int LE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic                 wr_half,
    input  logic [3:0]           wr_lane,
    input  logic [WORD_BITS-1:0] wr_data,
    input  logic                 start,
    input  logic                 start_half,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 C,
    output logic                 LE0,
    output logic                 LE1,
    output logic [8:0]           D
);

    localparam int NUM_LANES = 9;
    localparam int BIT_W     = $clog2(WORD_BITS + 1);
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LE_W      = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_t;

    // Word buffer, cleared by reset so an aborted frame leaves nothing behind
    logic [WORD_BITS-1:0] frame_buf_reg [2][NUM_LANES];

    // The selected half, presented to the loader in the start cycle
    logic [WORD_BITS-1:0] snap_word [NUM_LANES];

    // Per-lane shift registers; the bit currently on D has already left them
    logic [WORD_BITS-1:0] shift_reg  [NUM_LANES];
    logic [WORD_BITS-1:0] shift_next [NUM_LANES];

    state_t           state_reg,   state_next;
    logic [DIV_W-1:0] div_reg,     div_next;
    logic             phase_reg,   phase_next;   // 0: C low phase, 1: C high phase
    logic [BIT_W-1:0] bit_reg,     bit_next;
    logic [LE_W-1:0]  le_cnt_reg,  le_cnt_next;
    logic             half_reg,    half_next;
    logic             c_reg,       c_next;
    logic             le0_reg,     le0_next;
    logic             le1_reg,     le1_next;
    logic [8:0]       d_reg,       d_next;
    logic             busy_reg,    busy_next;
    logic             done_reg,    done_next;
    logic             overrun_reg, overrun_next;

    // Buffer write port: accepted in any state, out-of-range lanes match nothing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int h = 0; h < 2; h++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    frame_buf_reg[h][l] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int h = 0; h < 2; h++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (wr_half == 1'(h) && wr_lane == 4'(l)) begin
                        frame_buf_reg[h][l] <= wr_data;
                    end
                end
            end
        end
    end

    // Snapshot mux reads the buffer before any same-cycle write lands
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_snap
            assign snap_word[gi] = frame_buf_reg[start_half][gi];
        end
    endgenerate

    // State, counters, shift data and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            phase_reg   <= 1'b0;
            bit_reg     <= '0;
            le_cnt_reg  <= '0;
            half_reg    <= 1'b0;
            c_reg       <= 1'b0;
            le0_reg     <= 1'b0;
            le1_reg     <= 1'b0;
            d_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                shift_reg[l] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            phase_reg   <= phase_next;
            bit_reg     <= bit_next;
            le_cnt_reg  <= le_cnt_next;
            half_reg    <= half_next;
            c_reg       <= c_next;
            le0_reg     <= le0_next;
            le1_reg     <= le1_next;
            d_reg       <= d_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
            for (int l = 0; l < NUM_LANES; l++) begin
                shift_reg[l] <= shift_next[l];
            end
        end
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        phase_next   = phase_reg;
        bit_next     = bit_reg;
        le_cnt_next  = le_cnt_reg;
        half_next    = half_reg;
        c_next       = c_reg;
        le0_next     = le0_reg;
        le1_next     = le1_reg;
        d_next       = d_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        // A start that arrives mid-frame is dropped and only reported
        overrun_next = start && busy_reg;
        for (int l = 0; l < NUM_LANES; l++) begin
            shift_next[l] = shift_reg[l];
        end

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                if (start) begin
                    // Load the snapshot and present the MSB straight away
                    state_next = ST_SHIFT;
                    busy_next  = 1'b1;
                    half_next  = start_half;
                    div_next   = '0;
                    phase_next = 1'b0;
                    bit_next   = '0;
                    c_next     = 1'b0;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        d_next[l]     = snap_word[l][WORD_BITS-1];
                        shift_next[l] = snap_word[l] << 1;
                    end
                end
            end

            ST_SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (!phase_reg) begin
                        // End of low phase: D has settled, raise C
                        c_next     = 1'b1;
                        phase_next = 1'b1;
                    end else if (bit_reg == LAST_BIT) begin
                        // Last high phase finished: park C/D and latch
                        state_next  = ST_LATCH;
                        c_next      = 1'b0;
                        phase_next  = 1'b0;
                        d_next      = '0;
                        le_cnt_next = '0;
                        le0_next    = !half_reg;
                        le1_next    = half_reg;
                    end else begin
                        // Falling edge of C carries the next bit onto D
                        c_next     = 1'b0;
                        phase_next = 1'b0;
                        bit_next   = bit_reg + BIT_W'(1);
                        for (int l = 0; l < NUM_LANES; l++) begin
                            d_next[l]     = shift_reg[l][WORD_BITS-1];
                            shift_next[l] = shift_reg[l] << 1;
                        end
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end

            ST_LATCH: begin
                if (le_cnt_reg == LE_LAST) begin
                    state_next = ST_DONE;
                    le0_next   = 1'b0;
                    le1_next   = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    le_cnt_next = le_cnt_reg + LE_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign overrun = overrun_reg;
    assign C       = c_reg;
    assign LE0     = le0_reg;
    assign LE1     = le1_reg;

    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_dout
            assign D[gi] = d_reg[gi];
        end
    endgenerate

endmodule
